// File: rtl/ad80305_pkg.sv
// Shared constants and FSM encoding for the ad80305 RX DC-correction path.
package ad80305_pkg;

  localparam int DW_DEF       = 12;
  localparam int AVG_LOG2_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_UPDATE = 2'd2
  } dc_state_e;

endpackage

// File: rtl/ad80305_rx_dc_corr_if.sv
// Sample-stream bundle between the RX DDR interface, DC correction and its control registers.
interface ad80305_rx_dc_corr_if import ad80305_pkg::*; #(
  parameter int DW = DW_DEF
);

  logic          i_iqdata_fp;
  logic [DW-1:0] i_idata;
  logic [DW-1:0] i_qdata;
  logic          i_dc_bypass;
  logic          i_dc_set_sw;
  logic [7:0]    i_dc_corr_idata;
  logic [7:0]    i_dc_corr_qdata;
  logic          o_iqdata_fp;
  logic [DW-1:0] o_idata;
  logic [DW-1:0] o_qdata;
  logic [DW-1:0] o_aver_idata;
  logic [DW-1:0] o_aver_qdata;
  logic          o_aver_vld;

  modport master (
    output i_iqdata_fp, i_idata, i_qdata, i_dc_bypass, i_dc_set_sw,
           i_dc_corr_idata, i_dc_corr_qdata,
    input  o_iqdata_fp, o_idata, o_qdata, o_aver_idata, o_aver_qdata, o_aver_vld
  );

  modport slave (
    input  i_iqdata_fp, i_idata, i_qdata, i_dc_bypass, i_dc_set_sw,
           i_dc_corr_idata, i_dc_corr_qdata,
    output o_iqdata_fp, o_idata, o_qdata, o_aver_idata, o_aver_qdata, o_aver_vld
  );

endinterface

// File: rtl/ad80305_dc_sat_sub.sv
// Combinational sample-minus-offset with saturation back to the sample width.
module ad80305_dc_sat_sub import ad80305_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic signed [DW-1:0] sample,
  input  logic signed [DW-1:0] offset,
  output logic signed [DW-1:0] result
);

  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW:0] diff_s;

  // One guard bit: the top two bits disagree exactly when the difference left the DW range.
  always_comb begin
    diff_s = {sample[DW-1], sample} - {offset[DW-1], offset};
    if (diff_s[DW] != diff_s[DW-1]) begin
      result = diff_s[DW] ? SAT_MIN : SAT_MAX;
    end else begin
      result = diff_s[DW-1:0];
    end
  end

endmodule

// File: rtl/ad80305_rx_dc_corr.sv
// RX DC-offset estimator (windowed average) and two-cycle correction pipeline.
module ad80305_rx_dc_corr import ad80305_pkg::*; #(
  parameter int DW       = DW_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input logic                 i_fpga_clk_125p,
  input logic                 i_fpga_rst_125p,
  ad80305_rx_dc_corr_if.slave rx
);

  localparam int AW = DW + AVG_LOG2;
  localparam logic [AVG_LOG2:0] WIN_LEN  = {1'b1, {AVG_LOG2{1'b0}}};
  localparam logic [AVG_LOG2:0] CNT_ONE  = {{AVG_LOG2{1'b0}}, 1'b1};
  localparam logic [AVG_LOG2:0] CNT_ZERO = {(AVG_LOG2+1){1'b0}};
  localparam logic signed [AW-1:0] ACC_ZERO = {AW{1'b0}};
  localparam logic signed [DW-1:0] DW_ZERO  = {DW{1'b0}};

  dc_state_e             state_r;
  logic [AVG_LOG2:0]     cnt_r;
  logic [AVG_LOG2:0]     cnt_next_s;
  logic signed [AW-1:0]  acc_i_r, acc_q_r;
  logic signed [AW-1:0]  samp_i_ext_s, samp_q_ext_s;
  logic signed [AW-1:0]  aver_i_full_s, aver_q_full_s;
  logic signed [DW-1:0]  aver_i_r, aver_q_r;
  logic                  aver_vld_r;
  logic signed [DW-1:0]  off_i_s, off_q_s;
  logic                  stb1_r, byp1_r, stb2_r;
  logic signed [DW-1:0]  i1_r, q1_r, off_i1_r, off_q1_r;
  logic signed [DW-1:0]  sat_i_s, sat_q_s;
  logic signed [DW-1:0]  out_i_r, out_q_r;

  // Sign extension, window counter increment, floor average and offset selection.
  always_comb begin
    samp_i_ext_s  = {{AVG_LOG2{rx.i_idata[DW-1]}}, rx.i_idata};
    samp_q_ext_s  = {{AVG_LOG2{rx.i_qdata[DW-1]}}, rx.i_qdata};
    cnt_next_s    = cnt_r + CNT_ONE;
    aver_i_full_s = acc_i_r >>> AVG_LOG2;
    aver_q_full_s = acc_q_r >>> AVG_LOG2;
    off_i_s = rx.i_dc_set_sw ? {{(DW-8){rx.i_dc_corr_idata[7]}}, rx.i_dc_corr_idata} : aver_i_r;
    off_q_s = rx.i_dc_set_sw ? {{(DW-8){rx.i_dc_corr_qdata[7]}}, rx.i_dc_corr_qdata} : aver_q_r;
  end

  // Averaging FSM: accumulate a full window, publish the average, restart.
  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      acc_i_r    <= ACC_ZERO;
      acc_q_r    <= ACC_ZERO;
      aver_i_r   <= DW_ZERO;
      aver_q_r   <= DW_ZERO;
      aver_vld_r <= 1'b0;
    end else begin
      aver_vld_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_ACCUM: begin
          if (rx.i_iqdata_fp) begin
            acc_i_r <= acc_i_r + samp_i_ext_s;
            acc_q_r <= acc_q_r + samp_q_ext_s;
            cnt_r   <= cnt_next_s;
            state_r <= (cnt_next_s == WIN_LEN) ? ST_UPDATE : ST_ACCUM;
          end else begin
            state_r <= ST_ACCUM;
          end
        end
        ST_UPDATE: begin
          aver_i_r   <= aver_i_full_s[DW-1:0];
          aver_q_r   <= aver_q_full_s[DW-1:0];
          aver_vld_r <= 1'b1;
          state_r    <= ST_ACCUM;
          // A strobe landing here opens the next window rather than being dropped.
          if (rx.i_iqdata_fp) begin
            acc_i_r <= samp_i_ext_s;
            acc_q_r <= samp_q_ext_s;
            cnt_r   <= CNT_ONE;
          end else begin
            acc_i_r <= ACC_ZERO;
            acc_q_r <= ACC_ZERO;
            cnt_r   <= CNT_ZERO;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          acc_i_r <= ACC_ZERO;
          acc_q_r <= ACC_ZERO;
        end
      endcase
    end
  end

  ad80305_dc_sat_sub #(.DW(DW)) u_sat_i (.sample(i1_r), .offset(off_i1_r), .result(sat_i_s));
  ad80305_dc_sat_sub #(.DW(DW)) u_sat_q (.sample(q1_r), .offset(off_q1_r), .result(sat_q_s));

  // Correction pipeline: controls and offset are frozen with each sample on its strobe.
  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      stb1_r   <= 1'b0;
      byp1_r   <= 1'b0;
      i1_r     <= DW_ZERO;
      q1_r     <= DW_ZERO;
      off_i1_r <= DW_ZERO;
      off_q1_r <= DW_ZERO;
      stb2_r   <= 1'b0;
      out_i_r  <= DW_ZERO;
      out_q_r  <= DW_ZERO;
    end else begin
      stb1_r <= rx.i_iqdata_fp;
      if (rx.i_iqdata_fp) begin
        byp1_r   <= rx.i_dc_bypass;
        i1_r     <= rx.i_idata;
        q1_r     <= rx.i_qdata;
        off_i1_r <= off_i_s;
        off_q1_r <= off_q_s;
      end
      stb2_r <= stb1_r;
      if (stb1_r) begin
        out_i_r <= byp1_r ? i1_r : sat_i_s;
        out_q_r <= byp1_r ? q1_r : sat_q_s;
      end
    end
  end

  assign rx.o_iqdata_fp  = stb2_r;
  assign rx.o_idata      = out_i_r;
  assign rx.o_qdata      = out_q_r;
  assign rx.o_aver_idata = aver_i_r;
  assign rx.o_aver_qdata = aver_q_r;
  assign rx.o_aver_vld   = aver_vld_r;

endmodule

// File: tb/tb_ad80305_rx_dc_corr.sv
// Self-checking bench for ad80305_rx_dc_corr: fixed vectors, corner sequences, random streams vs a model.
module tb_ad80305_rx_dc_corr;

  localparam int DW  = 12;
  localparam int AL  = 12;
  localparam int WIN = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ad80305_rx_dc_corr_if #(.DW(DW)) bus ();

  ad80305_rx_dc_corr #(.DW(DW), .AVG_LOG2(AL)) dut (
    .i_fpga_clk_125p(clk),
    .i_fpga_rst_125p(rst),
    .rx             (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int vld_seen = 0;

  // Reference model: running window sums, current/pending averages, expected outputs.
  longint m_sum_i, m_sum_q;
  int m_cnt, m_aver_i, m_aver_q, m_pend_i, m_pend_q, m_pend_cyc;
  int m_d1_fp, m_d1_i, m_d1_q;
  int e_fp, e_i, e_q, e_vld;

  typedef struct {
    int i; int q; bit byp; bit sw; int ci; int cq; int exp_i; int exp_q;
  } vec_t;
  vec_t vecs[8];
  int   hist_i[WIN];
  int   hist_q[WIN];

  function automatic int floor_div(longint s, int d);
    longint qt;
    qt = s / d;
    if ((s % d) != 0 && s < 0) qt = qt - 1;
    return int'(qt);
  endfunction

  function automatic int sat(int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic chk(input string name, input integer act, input integer exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_sum_i = 0; m_sum_q = 0; m_cnt = 0;
    m_aver_i = 0; m_aver_q = 0; m_pend_i = 0; m_pend_q = 0; m_pend_cyc = -1;
    m_d1_fp = 0; m_d1_i = 0; m_d1_q = 0;
    e_fp = 0; e_i = 0; e_q = 0; e_vld = 0;
  endtask

  task automatic model_step();
    int si, sq, off_i, off_q, ni, nq;
    bit stb;
    if (rst == 1'b0) begin
      model_reset();
      return;
    end
    stb   = bus.i_iqdata_fp;
    si    = $signed(bus.i_idata);
    sq    = $signed(bus.i_qdata);
    off_i = bus.i_dc_set_sw ? int'($signed(bus.i_dc_corr_idata)) : m_aver_i;
    off_q = bus.i_dc_set_sw ? int'($signed(bus.i_dc_corr_qdata)) : m_aver_q;
    ni    = bus.i_dc_bypass ? si : sat(si - off_i);
    nq    = bus.i_dc_bypass ? sq : sat(sq - off_q);
    e_fp = m_d1_fp;
    if (m_d1_fp != 0) begin
      e_i = m_d1_i;
      e_q = m_d1_q;
    end
    m_d1_fp = int'(stb);
    if (stb) begin
      m_d1_i = ni;
      m_d1_q = nq;
    end
    e_vld = 0;
    if (m_pend_cyc == cyc + 1) begin
      m_aver_i = m_pend_i;
      m_aver_q = m_pend_q;
      e_vld    = 1;
    end
    if (stb) begin
      m_sum_i += si;
      m_sum_q += sq;
      m_cnt++;
      if (m_cnt == WIN) begin
        m_pend_i   = floor_div(m_sum_i, WIN);
        m_pend_q   = floor_div(m_sum_q, WIN);
        m_pend_cyc = cyc + 2;
        m_sum_i = 0; m_sum_q = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("o_iqdata_fp", bus.o_iqdata_fp, e_fp);
    chk("o_idata", $signed(bus.o_idata), e_i);
    chk("o_qdata", $signed(bus.o_qdata), e_q);
    chk("o_aver_idata", $signed(bus.o_aver_idata), m_aver_i);
    chk("o_aver_qdata", $signed(bus.o_aver_qdata), m_aver_q);
    chk("o_aver_vld", bus.o_aver_vld, e_vld);
    if (bus.o_aver_vld === 1'b1) vld_seen++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input bit stb, input int i, input int q, input bit byp,
                       input bit sw, input int ci, input int cq);
    bus.i_iqdata_fp     = stb;
    bus.i_idata         = 12'(i);
    bus.i_qdata         = 12'(q);
    bus.i_dc_bypass     = byp;
    bus.i_dc_set_sw     = sw;
    bus.i_dc_corr_idata = 8'(ci);
    bus.i_dc_corr_qdata = 8'(cq);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{i: 2045,  q: -2046, byp: 1'b0, sw: 1'b1, ci: -5,   cq: 5,    exp_i: 2047,  exp_q: -2048};
    vecs[1] = '{i: 100,   q: -100,  byp: 1'b0, sw: 1'b1, ci: 10,   cq: -10,  exp_i: 90,    exp_q: -90};
    vecs[2] = '{i: -2048, q: 2047,  byp: 1'b0, sw: 1'b1, ci: 127,  cq: -128, exp_i: -2048, exp_q: 2047};
    vecs[3] = '{i: -2000, q: 1000,  byp: 1'b0, sw: 1'b1, ci: -128, cq: 127,  exp_i: -1872, exp_q: 873};
    vecs[4] = '{i: 2047,  q: -2048, byp: 1'b1, sw: 1'b1, ci: -5,   cq: 5,    exp_i: 2047,  exp_q: -2048};
    vecs[5] = '{i: 5,     q: -5,    byp: 1'b0, sw: 1'b0, ci: 0,    cq: 0,    exp_i: 5,     exp_q: -5};
    vecs[6] = '{i: -1,    q: 0,     byp: 1'b0, sw: 1'b1, ci: -1,   cq: 1,    exp_i: 0,     exp_q: -1};
    vecs[7] = '{i: 1234,  q: -777,  byp: 1'b1, sw: 1'b0, ci: 0,    cq: 0,    exp_i: 1234,  exp_q: -777};
    model_reset();
    idle();

    // Outputs held at zero while reset is asserted.
    @(negedge clk);
    chk("rst_fp", bus.o_iqdata_fp, 0);
    chk("rst_i", $signed(bus.o_idata), 0);
    chk("rst_q", $signed(bus.o_qdata), 0);
    chk("rst_aver_i", $signed(bus.o_aver_idata), 0);
    chk("rst_aver_q", $signed(bus.o_aver_qdata), 0);
    chk("rst_vld", bus.o_aver_vld, 0);
    do_reset();

    // Fixed vectors: manual offsets, saturation, bypass, auto with zero average.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, vecs[k].i, vecs[k].q, vecs[k].byp, vecs[k].sw, vecs[k].ci, vecs[k].cq);
      tick();
      idle();
      tick();
      chk($sformatf("tbl%0d_fp", k), bus.o_iqdata_fp, 1);
      chk($sformatf("tbl%0d_i", k), $signed(bus.o_idata), vecs[k].exp_i);
      chk($sformatf("tbl%0d_q", k), $signed(bus.o_qdata), vecs[k].exp_q);
      tick();
      chk($sformatf("tbl%0d_hold_i", k), $signed(bus.o_idata), vecs[k].exp_i);
      tick();
    end

    // Reset mid-window discards value-50 samples; value-10 window follows.
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      drive(1'b1, 50, 50, 1'b0, 1'b0, 0, 0);
      tick();
    end
    do_reset();
    vld_seen = 0;
    for (int k = 0; k < WIN; k++) begin
      drive(1'b1, 10, 10, 1'b0, 1'b0, 0, 0);
      tick();
    end
    chk("r37_no_early_vld", vld_seen, 0);
    idle();
    tick();
    chk("r37_vld", vld_seen, 1);
    chk("r37_aver_i", $signed(bus.o_aver_idata), 10);
    chk("r37_aver_q", $signed(bus.o_aver_qdata), 10);

    // Auto mode: constant 100/-37 every fourth cycle.
    do_reset();
    vld_seen = 0;
    for (int k = 0; k < WIN; k++) begin
      drive(1'b1, 100, -37, 1'b0, 1'b0, 0, 0);
      tick();
      idle();
      repeat (3) tick();
    end
    chk("r33_vld_count", vld_seen, 1);
    chk("r33_aver_i", $signed(bus.o_aver_idata), 100);
    chk("r33_aver_q", $signed(bus.o_aver_qdata), -37);
    drive(1'b1, 100, -37, 1'b0, 1'b0, 0, 0);
    tick();
    idle();
    tick();
    chk("r33_corr_i", $signed(bus.o_idata), 0);
    chk("r33_corr_q", $signed(bus.o_qdata), 0);

    // Mode toggle on adjacent strobes: manual (offset 0) then auto (100/-37).
    drive(1'b1, 200, -37, 1'b0, 1'b1, 0, 0);
    tick();
    drive(1'b1, 200, -37, 1'b0, 1'b0, 0, 0);
    tick();
    chk("r38_manual_i", $signed(bus.o_idata), 200);
    chk("r38_manual_q", $signed(bus.o_qdata), -37);
    idle();
    tick();
    chk("r38_auto_i", $signed(bus.o_idata), 100);
    chk("r38_auto_q", $signed(bus.o_qdata), 0);

    // Back-to-back random stream: bypass for the first window, random modes afterwards.
    do_reset();
    vld_seen = 0;
    for (int k = 0; k < 2 * WIN + 3; k++) begin
      int ri, rq, rci, rcq;
      bit rbyp, rsw;
      ri   = int'($urandom_range(4095, 0)) - 2048;
      rq   = int'($urandom_range(4095, 0)) - 2048;
      rci  = int'($urandom_range(255, 0)) - 128;
      rcq  = int'($urandom_range(255, 0)) - 128;
      rsw  = 1'($urandom_range(1, 0));
      rbyp = (k < WIN) ? 1'b1 : 1'($urandom_range(1, 0));
      drive(1'b1, ri, rq, rbyp, rsw, rci, rcq);
      tick();
      if (k < WIN) begin
        hist_i[k] = ri;
        hist_q[k] = rq;
        if (k >= 1) begin
          chk("r35_byp_i", $signed(bus.o_idata), hist_i[k-1]);
          chk("r35_byp_q", $signed(bus.o_qdata), hist_q[k-1]);
        end
      end
    end
    idle();
    repeat (3) tick();
    chk("r36_vld_count", vld_seen, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ad80305_rx_dc_corr.md
AD80305_RX_DC_CORR -- requirements
Module: ad80305_rx_dc_corr

Interface
REQ-001 Parameter DW, default 12, I/Q sample width (signed two's complement).
REQ-002 Parameter AVG_LOG2, default 12, log2 of samples per DC-average window (4096).
REQ-003 i_fpga_clk_125p  in  1  sole clock; all logic is on its rising edge.
REQ-004 i_fpga_rst_125p  in  1  asynchronous assert, active-low reset.
REQ-005 i_iqdata_fp  in  1  sample strobe from the RX interface; one valid I/Q pair per high cycle.
REQ-006 i_idata, i_qdata  in  DW each  received I/Q samples, signed.
REQ-007 i_dc_bypass  in  1  1 = pass samples through uncorrected.
REQ-008 i_dc_set_sw  in  1  1 = subtract manual offset; 0 = subtract measured average.
REQ-009 i_dc_corr_idata, i_dc_corr_qdata  in  8 each  manual offset, signed.
REQ-010 o_iqdata_fp  out  1  output sample strobe.
REQ-011 o_idata, o_qdata  out  DW each  corrected samples, signed.
REQ-012 o_aver_idata, o_aver_qdata  out  DW each  latest measured DC average, signed.
REQ-013 o_aver_vld  out  1  one-cycle pulse when the averages update.

Function
REQ-014 The block shall update the accumulators only on cycles with i_iqdata_fp=1; strobes on consecutive cycles are each valid samples.
REQ-015 State machine: IDLE -> ACCUM on the first cycle after reset release; ACCUM -> UPDATE on the strobe that brings the sample count to 2^AVG_LOG2; UPDATE -> ACCUM unconditionally after one cycle.
REQ-016 Per-channel accumulators shall be DW+AVG_LOG2 bits wide, signed, with sign-extended input. They cannot overflow.
REQ-017 The window sample counter shall be AVG_LOG2+1 bits wide. It shall clear to 0 in UPDATE.
REQ-018 In UPDATE the block shall load o_aver_* with the accumulator arithmetically shifted right by AVG_LOG2 (floor), pulse o_aver_vld, and clear the accumulators.
REQ-019 A strobe arriving in UPDATE shall still be corrected. It shall count as sample 1 of the next window; neither the sample nor the strobe is lost.
REQ-020 Offset selection: i_dc_set_sw=1 shall use the sign-extended i_dc_corr_*; i_dc_set_sw=0 shall use o_aver_*.
REQ-021 Corrected output = sample minus offset, computed at DW+1 bits and saturated to [-2^(DW-1), 2^(DW-1)-1].
REQ-022 With i_dc_bypass=1, outputs shall equal the inputs unmodified. Latency shall be the same as the corrected path, and averaging shall continue.
REQ-023 Latency: o_iqdata_fp and o_idata/o_qdata shall appear exactly 2 cycles after the input strobe; o_iqdata_fp shall be a pure 2-cycle delay of i_iqdata_fp.
REQ-024 The block shall sample i_dc_bypass, i_dc_set_sw and i_dc_corr_* on the input strobe cycle; changes apply from the next sample, never mid-pipeline.
REQ-025 Before the first UPDATE, o_aver_* = 0, so auto mode subtracts 0.
REQ-026 o_idata/o_qdata shall hold their last value while o_iqdata_fp=0.

Reset
REQ-027 While reset is asserted, all outputs, accumulators, counter and pipeline registers shall be 0, and the FSM shall be in IDLE.
REQ-028 Reset asserted mid-window shall discard the partial accumulation; the first window after release starts at count 0.
REQ-029 Release is synchronous to i_fpga_clk_125p; the integrator supplies a synchronised release.

Structure
REQ-030 A shared package ad80305_pkg shall hold the FSM state encoding (IDLE, ACCUM, UPDATE) and the default DW and AVG_LOG2 constants.
REQ-031 Sub-module ad80305_dc_sat_sub (subtract + saturate, one instance per channel, combinational) shall be used. Everything else stays in the top module.
REQ-032 The block sits directly downstream of the ad80305 RX DDR interface and consumes its strobe/I/Q outputs unchanged.

Verification
REQ-033 Auto mode, AVG_LOG2=12: constant I=100, Q=-37 for 4096 strobes (strobe every 4 cycles) -> o_aver_vld pulses once; o_aver=100/-37; subsequent outputs 0/0.
REQ-034 Manual mode: i_dc_set_sw=1, i_dc_corr_idata=-5, I=2045 -> o_idata=2047 (saturated). i_dc_corr_qdata=+5, Q=-2046 -> o_qdata=-2048.
REQ-035 Bypass: i_dc_bypass=1 with a random stream -> outputs are bit-exact to the inputs, 2 cycles later. o_aver_* still update after 4096 strobes.
REQ-036 Back-to-back strobes on every cycle, with the last window strobe followed by a strobe in UPDATE -> no strobe dropped; the next window completes after exactly 4096 further strobes.
REQ-037 Reset asserted at sample 2000 of a window of value 50, then a stream of value 10 -> the first o_aver_vld occurs after 4096 post-reset strobes, with o_aver=10.
REQ-038 Toggle i_dc_set_sw between two strobes 1 cycle apart -> each output uses the mode sampled with its own input strobe.
